// File: rtl/octree_pkg.sv
// Shared types and default sizes for the octree node fetch arbiter.
package octree_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int ROM_DEPTH_DEF = 38;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
// Zero latency; the parent owns ptr and decides when a grant is consumed.
module rr_arbiter
  import octree_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_gnt && req[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/octree_fetch_arbiter.sv
// Round-robin octree ROM fetch arbiter, one fetch in flight, response 2 cycles after accept.
// Response held until its owner accepts; OCTREE_ADDR_CHECK_EN adds an out-of-range error path.
module octree_fetch_arbiter
  import octree_pkg::*;
#(
  parameter int NUM_REQ       = NUM_REQ_DEF,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ROM_DEPTH     = ROM_DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_err,
  output logic                             rom_ren,
  output logic [ADDRESS_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]            rom_dout
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef OCTREE_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_e                  state_q, state_d;
  logic [IDXW-1:0]         ptr_q, ptr_d;
  logic [IDXW-1:0]         gidx_q, gidx_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]      arb_req;
  logic [NUM_REQ-1:0]      arb_gnt;
  logic [IDXW-1:0]         arb_idx;
  logic                    arb_any;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic                    addr_oor;

  // Requests only compete while idle and out of reset.
  assign arb_req = (state_q == IDLE && !rst) ? req_valid : '0;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDXW)
  ) u_rr (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any_gnt (arb_any)
  );

  assign sel_addr = req_addr[arb_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign addr_oor = CHECK_EN && (sel_addr >= ADDRESS_WIDTH'(ROM_DEPTH));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;
    rom_ren    = 1'b0;
    rom_addr   = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_gnt;
          gidx_d    = arb_idx;
          ptr_d     = (arb_idx == IDXW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          rsp_err_d = addr_oor;
          if (addr_oor) begin
            rsp_data_d = '0;
            state_d    = RESP;
          end else begin
            rom_ren  = 1'b1;
            rom_addr = sel_addr;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        rsp_data_d = rom_dout;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready[gidx_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[gidx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = CHECK_EN && rsp_err_q;

endmodule

// File: tb/tb_octree_fetch_arbiter.sv
// Directed plus random checks of octree_fetch_arbiter against a transaction-timeline model.
module tb_octree_fetch_arbiter;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 38;
`ifdef OCTREE_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*AW-1:0]   req_addr;
  logic [DW-1:0]     rsp_data, rom_dout;
  logic              rsp_err, rom_ren;
  logic [AW-1:0]     rom_addr;

  always #5 clk = ~clk;

  octree_fetch_arbiter #(
    .NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ROM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rom_ren(rom_ren), .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  int vectors = 0;
  int miscompares = 0;
  int cycle_no = 0;

  logic [AW-1:0] addr [N];
  // Model: who owns the in-flight fetch, how many cycles since it was granted.
  int            m_owner = -1;
  int            m_age = 0;
  int            m_ptr = 0;
  logic [AW-1:0] m_addr = '0;
  bit            m_oor = 1'b0;
  int            last_g = -1;
  int            glog_idx[$];
  int            glog_cyc[$];

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return (a == 32'd5) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cycle_no, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, clock, advance model, ROM read.
  task automatic cyc(input bit r, input logic [N-1:0] rv, input logic [N-1:0] rr);
    int            g;
    int            lat;
    bit            oor_g;
    bit            e_ren;
    logic [N-1:0]  e_rr, e_rv;
    logic [AW-1:0] e_ra;
    bit            obs_ren;
    logic [AW-1:0] obs_ra;
    rst       = r;
    req_valid = rv;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr[i];
    #1;
    g = -1;
    if (m_owner < 0 && !r)
      for (int k = 0; k < N; k++)
        if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    oor_g = (g >= 0) ? (CHK && addr[g] >= DEPTH) : 1'b0;
    e_rr  = '0;
    if (g >= 0) e_rr[g] = 1'b1;
    e_ren = (g >= 0) && !oor_g;
    e_ra  = e_ren ? addr[g] : '0;
    lat   = m_oor ? 1 : 2;
    e_rv  = '0;
    if (m_owner >= 0 && m_age >= lat) e_rv[m_owner] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(e_rr));
    chk("rom_ren", 64'(rom_ren), 64'(e_ren));
    chk("rom_addr", 64'(rom_addr), 64'(e_ra));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    if (e_rv != '0) begin
      chk("rsp_data", 64'(rsp_data), m_oor ? 64'd0 : 64'(rom_word(m_addr)));
      chk("rsp_err", 64'(rsp_err), 64'(m_oor));
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin
        glog_idx.push_back(i);
        glog_cyc.push_back(cycle_no);
      end
    obs_ren = rom_ren;
    obs_ra  = rom_addr;
    last_g  = g;
    @(posedge clk);
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner >= 0) begin
      if (m_age >= lat && rr[m_owner]) m_owner = -1;
      else m_age++;
    end else if (g >= 0) begin
      m_owner = g;
      m_age   = 1;
      m_ptr   = (g + 1) % N;
      m_addr  = addr[g];
      m_oor   = oor_g;
    end
    cycle_no++;
    #1;
    rom_dout = obs_ren ? rom_word(obs_ra) : DW'($urandom);
  endtask

  initial begin
    logic [N-1:0] pend;
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_addr = '0; rom_dout = '0;
    for (int i = 0; i < N; i++) addr[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rom_ren", 64'(rom_ren), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    cyc(1'b1, 4'b1111, 4'b1111);

    // Single fetch of word 5.
    addr[0] = 32'd5;
    cyc(1'b0, 4'b0001, 4'b1111);
    repeat (3) cyc(1'b0, 4'b0000, 4'b1111);

    // Fairness with everyone requesting.
    cyc(1'b1, 4'b0000, 4'b0000);
    glog_idx.delete();
    glog_cyc.delete();
    for (int i = 0; i < N; i++) addr[i] = AW'($urandom_range(DEPTH - 1));
    repeat (15) cyc(1'b0, 4'b1111, 4'b1111);
    chk("fair_count", 64'(glog_idx.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("fair_idx", (i < glog_idx.size()) ? 64'(glog_idx[i]) : 64'hFFFF, 64'(i % N));
      if (i > 0 && i < glog_idx.size())
        chk("fair_gap", 64'(glog_cyc[i] - glog_cyc[i-1]), 64'd3);
    end

    // Backpressure on requester 2 for five response cycles.
    cyc(1'b0, 4'b0000, 4'b1111);
    addr[2] = 32'd17;
    cyc(1'b0, 4'b0100, 4'b1011);
    repeat (6) cyc(1'b0, 4'b1011, 4'b1011);
    cyc(1'b0, 4'b1011, 4'b1111);
    repeat (3) cyc(1'b0, 4'b0000, 4'b1111);

    // Reset while the fetch is in WAIT.
    cyc(1'b0, 4'b0001, 4'b1111);
    cyc(1'b1, 4'b0000, 4'b1111);
    cyc(1'b0, 4'b0000, 4'b1111);
    glog_idx.delete();
    cyc(1'b0, 4'b1010, 4'b1111);
    chk("rst_first_grant", (glog_idx.size() > 0) ? 64'(glog_idx[0]) : 64'hFFFF, 64'd1);
    repeat (3) cyc(1'b0, 4'b0000, 4'b1111);

    // Address at ROM_DEPTH.
    addr[0] = 32'd38;
    cyc(1'b0, 4'b0001, 4'b1111);
    repeat (3) cyc(1'b0, 4'b0000, 4'b1111);

    // Random traffic.
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(19) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          addr[i] = AW'($urandom_range(47));
        end
      end
      cyc(1'b0, pend, N'($urandom_range(15)));
      if (last_g >= 0) pend[last_g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
